event_rx_decoder: RTL

- Consumer-side block for the pixel arbiter's event output.
- Captures each granted event word, checks it, and splits it into timestamp, row, column and polarity fields.
- Buffers decoded events in a small FIFO and presents them downstream on a valid/ready handshake.
- Sits directly after top_arb. Counts events dropped on overflow and malformed words. Handles enable-driven drain.

---
 rtl/event_rx_pkg.sv | 33 +++
 rtl/event_rx_fifo.sv | 67 ++++++
 rtl/event_rx_decoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/event_rx_pkg.sv
// Shared types and constants for the pixel-arbiter event receiver.
// Optional macro EVT_RX_TS_DELTA_EN (consumed by event_rx_decoder) switches out_ts_o to timestamp deltas.
package event_rx_pkg;

  localparam int DEF_ROWS       = 4;
  localparam int DEF_COLS       = 4;
  localparam int DEF_POLARITY   = 2;
  localparam int DEF_TS_WIDTH   = 8;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_CNT_W      = 16;

  localparam int DEF_ROW_AW = $clog2(DEF_ROWS);
  localparam int DEF_COL_AW = $clog2(DEF_COLS);
  localparam int DEF_WIDTH  = DEF_TS_WIDTH + DEF_ROW_AW + DEF_COL_AW + DEF_POLARITY;

  localparam logic [1:0] POL_ON  = 2'b01;
  localparam logic [1:0] POL_OFF = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rx_state_t;

  // Decoded event at the default geometry; polarity is reduced to 1 = ON, 0 = OFF.
  typedef struct packed {
    logic [DEF_TS_WIDTH-1:0] ts;
    logic [DEF_ROW_AW-1:0]   row;
    logic [DEF_COL_AW-1:0]   col;
    logic                    pol;
  } rx_evt_t;

endpackage

// File: rtl/event_rx_fifo.sv
// Synchronous FIFO with first-word fall-through head; output reads as zero while empty.
// Occupancy drives full/empty so the pointers can wrap naturally at power-of-two depth.
module event_rx_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = pop_i && !w_empty;
  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign w_push  = push_i && (!w_full || w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout_o  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign count_o = r_count;

endmodule

// File: rtl/event_rx_decoder.sv
// Decodes arbiter event words, rejects malformed ones, buffers and drains them to a valid/ready sink.
// Define EVT_RX_TS_DELTA_EN to report timestamp deltas between pushed events instead of absolute values.
module event_rx_decoder
  import event_rx_pkg::*;
#(
  parameter  int ROWS       = DEF_ROWS,
  parameter  int COLS       = DEF_COLS,
  parameter  int POLARITY   = DEF_POLARITY,
  parameter  int TS_WIDTH   = DEF_TS_WIDTH,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter  int CNT_W      = DEF_CNT_W,
  localparam int ROW_AW     = $clog2(ROWS),
  localparam int COL_AW     = $clog2(COLS),
  localparam int WIDTH      = TS_WIDTH + ROW_AW + COL_AW + POLARITY,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic                evt_valid_i,
  input  logic [WIDTH-1:0]    evt_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [TS_WIDTH-1:0] out_ts_o,
  output logic [ROW_AW-1:0]   out_row_o,
  output logic [COL_AW-1:0]   out_col_o,
  output logic                out_pol_o,
  output logic [CW-1:0]       fifo_count_o,
  output logic [CNT_W-1:0]    drop_cnt_o,
  output logic [CNT_W-1:0]    err_cnt_o,
  output logic                drain_done_o,
  output logic [1:0]          state_o
);

  // Handshake: an event transfers on a rising edge where out_valid_o && out_ready_i;
  // while out_valid_o=1 and out_ready_i=0 the head and every out_* field hold stable.

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [ROW_AW-1:0]   row;
    logic [COL_AW-1:0]   col;
    logic                pol;
  } evt_t;

  rx_state_t r_state;
  rx_state_t w_state_nxt;

  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [POLARITY-1:0] w_pol;
  logic [COL_AW-1:0]   w_col;
  logic [ROW_AW-1:0]   w_row;
  logic [TS_WIDTH-1:0] w_ts;
  logic [TS_WIDTH-1:0] w_ts_store;
  logic                w_legal;
  logic                w_strobe;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_err;
  logic                w_full;
  logic                w_empty;
  evt_t                w_din;
  evt_t                w_head;

  assign w_pol = evt_data_i[POLARITY-1:0];
  assign w_col = evt_data_i[POLARITY +: COL_AW];
  assign w_row = evt_data_i[POLARITY+COL_AW +: ROW_AW];
  assign w_ts  = evt_data_i[WIDTH-1 -: TS_WIDTH];

  assign w_legal = ((w_pol == POLARITY'(POL_ON)) || (w_pol == POLARITY'(POL_OFF)))
                && (int'(w_row) < ROWS) && (int'(w_col) < COLS);

  assign w_strobe = (r_state == RUN) && evt_valid_i;
  assign w_pop    = out_valid_o && out_ready_i;
  assign w_push   = w_strobe && w_legal && (!w_full || w_pop);
  assign w_drop   = w_strobe && w_legal && w_full && !w_pop;
  assign w_err    = w_strobe && !w_legal;

`ifdef EVT_RX_TS_DELTA_EN
  logic [TS_WIDTH-1:0] r_prev_ts;
  logic                r_first;

  // The first push of each run reports its absolute timestamp.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_prev_ts <= '0;
      r_first   <= 1'b1;
    end else if (r_state == IDLE && enable_i) begin
      r_first   <= 1'b1;
    end else if (w_push) begin
      r_prev_ts <= w_ts;
      r_first   <= 1'b0;
    end
  end

  assign w_ts_store = r_first ? w_ts : (w_ts - r_prev_ts);
`else
  assign w_ts_store = w_ts;
`endif

  assign w_din = '{ts: w_ts_store, row: w_row, col: w_col, pol: (w_pol == POLARITY'(POL_ON))};

  event_rx_fifo #(
    .W     ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (w_din),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (fifo_count_o)
  );

  // enable_i wins over the empty exit so a quick re-enable never emits a drain pulse.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable_i) w_state_nxt = RUN;
      RUN:     if (!enable_i) w_state_nxt = DRAIN;
      DRAIN: begin
        if (enable_i) begin
          w_state_nxt = RUN;
        end else if (w_empty) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
      if (w_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign out_valid_o  = !w_empty;
  assign out_ts_o     = w_head.ts;
  assign out_row_o    = w_head.row;
  assign out_col_o    = w_head.col;
  assign out_pol_o    = w_head.pol;
  assign drop_cnt_o   = r_drop_cnt;
  assign err_cnt_o    = r_err_cnt;
  assign drain_done_o = (r_state == DRAIN) && !enable_i && w_empty;
  assign state_o      = r_state;

endmodule
